// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial even-parity checker.
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StParity
  } state_e;

  // Value of data ^ parity for a good frame.
  localparam logic PAR_EVEN = 1'b0;

  // Bit counter width: cnt must be able to hold DATA_W itself.
  function automatic int unsigned cnt_width(int unsigned data_w);
    return (data_w <= 1) ? 1 : $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial input stream plus decoded-frame outputs of the parity checker.
interface serial_parity_checker_if #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CNT_W  = 8
);

  logic              i_x;
  logic              i_valid;
  logic              i_sof;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              o_perr;
  logic              o_busy;
  logic [CNT_W-1:0]  o_err_cnt;

  // Link side: drives the bit stream, observes decoded frames.
  modport master (
    output i_x, i_valid, i_sof,
    input  o_data, o_valid, o_perr, o_busy, o_err_cnt
  );

  // Checker side.
  modport slave (
    input  i_x, i_valid, i_sof,
    output o_data, o_valid, o_perr, o_busy, o_err_cnt
  );

endinterface

// File: rtl/parity_acc.sv
// Toggle register holding the running parity of a frame.
module parity_acc (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_load_val,
  input  logic i_tgl_en,
  input  logic i_tgl_val,
  output logic o_q
);

  logic acc_q, acc_d;

  // Load takes priority over toggle so a restart always reseeds the parity.
  always_comb begin
    acc_d = acc_q;
    if (i_load) begin
      acc_d = i_load_val;
    end else if (i_tgl_en) begin
      acc_d = acc_q ^ i_tgl_val;
    end
  end

  // Parity state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign o_q = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames of DATA_W bits plus an even-parity bit,
// flags parity errors and keeps a saturating bad-frame count.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned CNT_W  = 8
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  serial_parity_checker_if.slave bus
);

  localparam int unsigned CntBw = cnt_width(DATA_W);

  state_e            state_q, state_d;
  logic [CntBw-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic acc;
  logic acc_load;
  logic acc_tgl;
  logic start;
  logic frame_err;

  // An sof beat restarts reception from any state, aborting a partial frame.
  assign start     = bus.i_valid && bus.i_sof;
  assign frame_err = ((acc ^ bus.i_x) != PAR_EVEN);

  parity_acc u_parity_acc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (acc_load),
    .i_load_val (bus.i_x),
    .i_tgl_en   (acc_tgl),
    .i_tgl_val  (bus.i_x),
    .o_q        (acc)
  );

  // Next-state: FSM, bit counter, shift register and registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    err_cnt_d = err_cnt_q;
    acc_load  = 1'b0;
    acc_tgl   = 1'b0;

    if (start) begin
      shift_d    = '0;
      shift_d[0] = bus.i_x;
      cnt_d      = CntBw'(1);
      acc_load   = 1'b1;
      state_d    = (DATA_W == 1) ? StParity : StData;
    end else if (bus.i_valid) begin
      unique case (state_q)
        StData: begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (cnt_q == CntBw'(i)) begin
              shift_d[i] = bus.i_x;
            end
          end
          acc_tgl = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == CntBw'(DATA_W)) begin
            state_d = StParity;
          end
        end
        StParity: begin
          data_d  = shift_q;
          perr_d  = frame_err;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
          if (frame_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        default: begin
          // Non-sof beats in idle are ignored.
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.o_data    = data_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_perr    = perr_q;
  assign bus.o_busy    = (state_q != StIdle);
  assign bus.o_err_cnt = err_cnt_q;

endmodule
